// File: rtl/setup_sweep_pkg.sv
// Shared state encoding and default constants for the setup-time sweep generator.
package setup_sweep_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_LEAD,
    S_EDGE,
    S_REL,
    S_DONE
  } state_t;

  localparam int DEF_MW          = 8;
  localparam int DEF_SETUP_START = 2;
  localparam int DEF_SETUP_STEP  = 1;
  localparam int DEF_SETUP_END   = 10;
  localparam int DEF_REF_HIGH    = 4;
  localparam int DEF_GAP         = 8;

endpackage

// File: rtl/setup_sweep_gen_cnt.sv
// Loadable down-counter with zero flag; times the GAP, LEAD and EDGE phases.
module sweep_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/setup_sweep_gen.sv
// Setup-time sweep stimulus generator. Optional macro SETUP_SWEEP_NEG_EDGE_EN
// adds an edge_sel input choosing an active-low reference.
module setup_sweep_gen
  import setup_sweep_pkg::*;
#(
  parameter int MW          = DEF_MW,
  parameter int SETUP_START = DEF_SETUP_START,
  parameter int SETUP_STEP  = DEF_SETUP_STEP,
  parameter int SETUP_END   = DEF_SETUP_END,
  parameter int REF_HIGH    = DEF_REF_HIGH,
  parameter int GAP         = DEF_GAP
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          notify,
  output logic          data,
  output logic          reference,
  output logic [MW-1:0] margin,
  output logic          busy,
  output logic          done,
  output logic [MW-1:0] min_pass,
  output logic          min_pass_valid
`ifdef SETUP_SWEEP_NEG_EDGE_EN
  ,
  input  logic          edge_sel
`endif
);

  // Counter reload values are "duration - 1" since the zero cycle is the last one.
  localparam logic [MW-1:0] START_V = MW'(SETUP_START);
  localparam logic [MW-1:0] GAP_LD  = MW'(GAP - 1);
  localparam logic [MW-1:0] REF_LD  = MW'(REF_HIGH - 1);
  localparam logic [MW:0]   STEP_V  = (MW+1)'(SETUP_STEP);
  localparam logic [MW:0]   END_V   = (MW+1)'(SETUP_END);

  state_t        state, state_nxt;
  logic          cnt_load;
  logic [MW-1:0] cnt_val;
  logic          cnt_zero;
  logic          sweep_init;
  logic          lead_enter;
  logic          rel_exit;
  logic          ref_act;
  logic          viol;
  logic [MW:0]   margin_nxt;
  logic          last_step;

  // One extra bit so a step past 2^MW-1 is seen as "beyond the end", never a wrap.
  assign margin_nxt = {1'b0, margin} + STEP_V;
  assign last_step  = (margin_nxt > END_V);

  sweep_cnt #(.W(MW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    cnt_load   = 1'b0;
    cnt_val    = GAP_LD;
    sweep_init = 1'b0;
    lead_enter = 1'b0;
    rel_exit   = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        sweep_init = 1'b1;
        cnt_load   = 1'b1;
        state_nxt  = S_GAP;
      end
      S_GAP: if (cnt_zero) begin
        cnt_load   = 1'b1;
        cnt_val    = margin - MW'(1);
        lead_enter = 1'b1;
        state_nxt  = S_LEAD;
      end
      S_LEAD: if (cnt_zero) begin
        cnt_load  = 1'b1;
        cnt_val   = REF_LD;
        state_nxt = S_EDGE;
      end
      S_EDGE: if (cnt_zero) state_nxt = S_REL;
      S_REL: begin
        rel_exit = 1'b1;
        if (last_step) begin
          state_nxt = S_DONE;
        end else begin
          cnt_load  = 1'b1;
          state_nxt = S_GAP;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    data    = (state == S_LEAD) || (state == S_EDGE) || (state == S_REL);
    ref_act = (state == S_EDGE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      margin         <= START_V;
      min_pass       <= '0;
      min_pass_valid <= 1'b0;
      viol           <= 1'b0;
    end else begin
      if (sweep_init) begin
        margin         <= START_V;
        min_pass       <= '0;
        min_pass_valid <= 1'b0;
      end
      if (lead_enter) begin
        viol <= 1'b0;
      end else if (((state == S_EDGE) || (state == S_REL)) && notify) begin
        viol <= 1'b1;
      end
      // notify in the REL cycle itself must also disqualify this step.
      if (rel_exit) begin
        if (!viol && !notify && !min_pass_valid) begin
          min_pass       <= margin;
          min_pass_valid <= 1'b1;
        end
        if (!last_step) margin <= margin_nxt[MW-1:0];
      end
    end
  end

`ifdef SETUP_SWEEP_NEG_EDGE_EN
  logic ref_pol;

  always_ff @(posedge clk) begin
    if (reset)           ref_pol <= 1'b0;
    else if (sweep_init) ref_pol <= edge_sel;
  end

  assign reference = ref_act ^ ref_pol;
`else
  assign reference = ref_act;
`endif

endmodule

// File: tb/tb_setup_sweep_gen.sv
// Directed self-checking bench for setup_sweep_gen: default build plus a
// narrow MW=4 instance; edge_sel checks run only with SETUP_SWEEP_NEG_EDGE_EN.
module tb_setup_sweep_gen;

  logic clk = 1'b0;
  logic reset, start1, start2, notify, edge_sel;

  logic       data1, ref1, busy1, done1, mpv1;
  logic [7:0] margin1, mp1;
  logic       data2, ref2, busy2, done2, mpv2;
  logic [3:0] margin2, mp2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  setup_sweep_gen dut1 (
    .clk(clk), .reset(reset), .start(start1), .notify(notify),
    .data(data1), .reference(ref1), .margin(margin1), .busy(busy1),
    .done(done1), .min_pass(mp1), .min_pass_valid(mpv1)
`ifdef SETUP_SWEEP_NEG_EDGE_EN
    , .edge_sel(edge_sel)
`endif
  );

  setup_sweep_gen #(.MW(4), .SETUP_START(14), .SETUP_STEP(3), .SETUP_END(15)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .notify(notify),
    .data(data2), .reference(ref2), .margin(margin2), .busy(busy2),
    .done(done2), .min_pass(mp2), .min_pass_valid(mpv2)
`ifdef SETUP_SWEEP_NEG_EDGE_EN
    , .edge_sel(edge_sel)
`endif
  );

  int         sel = 0;
  logic       s_data, s_ref, s_busy, s_done, s_mpv;
  logic [7:0] s_margin, s_mp;

  always_comb begin
    if (sel == 0) begin
      s_data = data1; s_ref = ref1; s_busy = busy1; s_done = done1;
      s_mpv = mpv1; s_margin = margin1; s_mp = mp1;
    end else begin
      s_data = data2; s_ref = ref2; s_busy = busy2; s_done = done2;
      s_mpv = mpv2; s_margin = {4'b0, margin2}; s_mp = {4'b0, mp2};
    end
  end

  int lead_q[$];
  int marg_q[$];
  int width_q[$];
  int done_cnt;
  bit timed_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Runs one sweep on the selected instance, recording per-step lead, margin
  // and reference-active width. mode: 0 quiet, 1 notify in active ref while
  // margin<5, 2 notify always, 3 notify only while data leads the reference.
  task automatic run_sweep(input int dut, input int mode, input bit pol);
    int  rise_cyc, act_start;
    bit  pd, pr, act, seen;
    lead_q.delete(); marg_q.delete(); width_q.delete();
    done_cnt = 0; timed_out = 1'b1;
    rise_cyc = 0; act_start = 0; pd = 0; pr = 0; seen = 0;
    sel = dut;
    @(negedge clk);
    if (dut == 0) start1 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start2 = 1'b0;
    for (int c = 0; c < 600; c++) begin
      act = s_ref ^ pol;
      if (s_data && !pd) rise_cyc = c;
      if (act && !pr) begin
        lead_q.push_back(c - rise_cyc);
        marg_q.push_back(int'(s_margin));
        act_start = c;
        seen = 1'b1;
      end
      if (!act && pr) width_q.push_back(c - act_start);
      if (!s_data) seen = 1'b0;
      if (s_done) done_cnt++;
      if (!s_busy && done_cnt > 0) begin
        timed_out = 1'b0;
        break;
      end
      pd = s_data; pr = act;
      case (mode)
        1:       notify = act && (s_margin < 8'd5);
        2:       notify = 1'b1;
        3:       notify = s_data && !seen;
        default: notify = 1'b0;
      endcase
      @(negedge clk);
    end
    notify = 1'b0;
  endtask

  initial begin
    bit got;
    reset = 1'b1; start1 = 1'b0; start2 = 1'b0; notify = 1'b0; edge_sel = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_margin", margin1, 2);
    check("rst_data", data1, 0);
    check("rst_ref", ref1, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_min_pass", mp1, 0);
    check("rst_valid", mpv1, 0);

    // Default sweep, no violations: margins 2..10, lead equals margin.
    run_sweep(0, 0, 1'b0);
    check("sw_timeout", timed_out, 0);
    check("sw_steps", lead_q.size(), 9);
    for (int i = 0; i < lead_q.size(); i++) begin
      check($sformatf("sw_margin[%0d]", i), marg_q[i], 2 + i);
      check($sformatf("sw_lead[%0d]", i), lead_q[i], 2 + i);
      check($sformatf("sw_width[%0d]", i), width_q[i], 4);
    end
    check("sw_done_once", done_cnt, 1);
    check("sw_busy_after", s_busy, 0);
    check("sw_margin_end", s_margin, 10);
    check("sw_min_pass", s_mp, 2);
    check("sw_valid", s_mpv, 1);

    run_sweep(0, 1, 1'b0);
    check("lt5_timeout", timed_out, 0);
    check("lt5_min_pass", s_mp, 5);
    check("lt5_valid", s_mpv, 1);

    run_sweep(0, 2, 1'b0);
    check("all_timeout", timed_out, 0);
    check("all_valid", s_mpv, 0);
    check("all_min_pass", s_mp, 0);

    run_sweep(0, 3, 1'b0);
    check("lead_timeout", timed_out, 0);
    check("lead_min_pass", s_mp, 2);
    check("lead_valid", s_mpv, 1);

    // Narrow counters: 14+3 overflows 4 bits and must end the sweep, not wrap.
    run_sweep(1, 0, 1'b0);
    check("n4_timeout", timed_out, 0);
    check("n4_steps", lead_q.size(), 1);
    if (lead_q.size() > 0) begin
      check("n4_margin", marg_q[0], 14);
      check("n4_lead", lead_q[0], 14);
      check("n4_width", width_q[0], 4);
    end
    check("n4_done_once", done_cnt, 1);
    check("n4_margin_end", s_margin, 14);
    check("n4_min_pass", s_mp, 14);
    sel = 0;

    // Reset beats a simultaneous start.
    @(negedge clk);
    reset = 1'b1; start1 = 1'b1;
    @(negedge clk);
    reset = 1'b0; start1 = 1'b0;
    check("rs_busy", busy1, 0);
    @(negedge clk);
    check("rs_busy_hold", busy1, 0);

    // Reset in the middle of EDGE.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      if (ref1) got = 1'b1; else @(negedge clk);
    end
    check("me_reached", got, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("me_ref", ref1, 0);
    check("me_data", data1, 0);
    check("me_busy", busy1, 0);
    check("me_margin", margin1, 2);

    // start while busy must not restart the sweep.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      if (margin1 == 8'd3 && data1) got = 1'b1; else @(negedge clk);
    end
    check("bs_reached", got, 1);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    check("bs_margin", margin1, 3);
    check("bs_busy", busy1, 1);
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      if (done1) got = 1'b1; else @(negedge clk);
    end
    check("bs_done", got, 1);
    check("bs_margin_end", margin1, 10);

`ifdef SETUP_SWEEP_NEG_EDGE_EN
    edge_sel = 1'b1;
    run_sweep(0, 0, 1'b1);
    edge_sel = 1'b0;
    check("ne_timeout", timed_out, 0);
    check("ne_steps", lead_q.size(), 9);
    if (lead_q.size() > 0) begin
      check("ne_lead", lead_q[0], 2);
      check("ne_width", width_q[0], 4);
    end
    check("ne_idle_ref", ref1, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
